// File: rtl/div16_seq.sv
// div16_seq: iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Start/busy/done handshake; results and the zero flag hold until the next FIX edge.
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, raw_q, raw_d, r_q, r_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, dbz_q, dbz_d;
  logic [WIDTH:0] sh, t;
  logic accept, a_neg, b_neg;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign a_neg  = is_signed && dividend[WIDTH-1];
  assign b_neg  = is_signed && divisor[WIDTH-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? ((divisor == '0) ? FIX : RUN) : IDLE;
      RUN:        state_d = (count_q == CW'(WIDTH - 1)) ? FIX : RUN;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    busy        = state_q == RUN || state_q == FIX;
    done        = state_q == DONE;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end
  // Datapath: dvd_q shifts the dividend out and the quotient bits in at the LSB.
  always_comb begin
    sh      = {r_q, dvd_q[WIDTH-1]};
    t       = sh - {1'b0, dvs_q};
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    if (accept) begin
      dvd_d   = a_neg ? -dividend : dividend;
      dvs_d   = b_neg ? -divisor : divisor;
      raw_d   = dividend;
      r_d     = '0;
      count_d = '0;
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
      zero_d  = divisor == '0;
    end else if (state_q == RUN) begin
      r_d     = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
      dvd_d   = {dvd_q[WIDTH-2:0], ~t[WIDTH]};
      count_d = count_q + CW'(1);
    end else if (state_q == FIX) begin
      quo_d = zero_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
      rem_d = zero_q ? raw_q : (rneg_q ? -r_q : r_q);
      dbz_d = zero_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule

// File: tb/tb_div16_seq.sv
// tb_div16_seq: directed vectors with hand-computed results for div16_seq.
module tb_div16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int n_chk = 0;
  int n_pass = 0;
  int lat, bcyc, n;

  div16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_res(input string tag, input logic [15:0] q, input logic [15:0] r, input logic z);
    check({tag, "_q"}, quotient, q);
    check({tag, "_r"}, remainder, r);
    check({tag, "_dbz"}, div_by_zero, z);
  endtask

  // Accept edge k, then sample #1 after each edge; lat = edges from k to first done.
  // With inj set, a start with other operands is pulsed while the unit is in RUN.
  task automatic run_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input bit inj, output int l, output int bc);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    l = 0; bc = 0;
    while (!done && l < 40) begin
      if (busy) bc++;
      if (inj && l == 5) begin
        dividend = 16'd9; divisor = 16'd3; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1 l++;
    end
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_res("rst", 16'h0000, 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    run_div(1'b0, 16'd100, 16'd7, 1'b0, lat, bcyc);
    check("u100_7_lat", lat, 17);
    check("u100_7_busy", bcyc, 17);
    check_res("u100_7", 16'd14, 16'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("u100_7_hold_q", quotient, 16'd14);
    check("u100_7_done_low", done, 0);

    run_div(1'b1, 16'hFFF9, 16'h0002, 1'b0, lat, bcyc);
    check_res("sm7_2", 16'hFFFD, 16'hFFFF, 1'b0);
    run_div(1'b1, 16'h0007, 16'hFFFE, 1'b0, lat, bcyc);
    check_res("s7_m2", 16'hFFFD, 16'h0001, 1'b0);

    run_div(1'b0, 16'd1234, 16'd0, 1'b0, lat, bcyc);
    check("dz_lat", lat, 1);
    check_res("dz", 16'hFFFF, 16'h04D2, 1'b1);
    run_div(1'b0, 16'd6, 16'd3, 1'b0, lat, bcyc);
    check_res("u6_3", 16'd2, 16'd0, 1'b0);

    run_div(1'b1, 16'h8000, 16'hFFFF, 1'b0, lat, bcyc);
    check_res("smin_m1", 16'h8000, 16'h0000, 1'b0);
    run_div(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat, bcyc);
    check_res("umax_1", 16'hFFFF, 16'h0000, 1'b0);
    run_div(1'b1, 16'h8000, 16'h0007, 1'b0, lat, bcyc);
    check_res("smin_7", 16'hEDB7, 16'hFFFF, 1'b0);
    run_div(1'b0, 16'h8000, 16'h0007, 1'b0, lat, bcyc);
    check_res("u8000_7", 16'h1249, 16'h0001, 1'b0);
    run_div(1'b0, 16'd5, 16'd9, 1'b0, lat, bcyc);
    check_res("u5_9", 16'd0, 16'd5, 1'b0);

    run_div(1'b0, 16'd100, 16'd7, 1'b1, lat, bcyc);
    check("inj_lat", lat, 17);
    check_res("inj", 16'd14, 16'd2, 1'b0);

    // done is up now; hold start through DONE for a back-to-back division
    is_signed = 1'b0; dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("b2b_pulse", done, 0);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1 n++;
    end
    check("b2b_gap", n, 18);
    check_res("b2b", 16'd10, 16'd0, 1'b0);

    @(negedge clk);
    is_signed = 1'b0; dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check_res("mid_rst", 16'h0000, 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1 if (done) n++;
    end
    check("rst_no_done", n, 0);
    run_div(1'b0, 16'd50, 16'd5, 1'b0, lat, bcyc);
    check("post_rst_lat", lat, 17);
    check_res("post_rst", 16'd10, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
